// File: rtl/opb_register_bank_simulink2ppc.sv
// opb_register_bank_simulink2ppc
//   Presents C_NUM_CH fabric words as read-only OPB registers, either tracking
//   the fabric live (per-channel user_valid strobes) or as a coherent snapshot
//   of all channels taken on snap_trig while armed.
//
//   Ports
//     OPB_Clk, OPB_Rst        : bus clock, async active-high reset
//     OPB_ABus/BE/DBus/RNW    : OPB slave request (IBM bit order, bit 31 = LSB)
//     OPB_select, OPB_seqAddr : transfer qualifier; seqAddr is unused
//     Sl_DBus, Sl_xferAck     : registered read data and one-cycle acknowledge
//     Sl_errAck/retry/toutSup : tied low
//     user_data_in            : channel i at [i*W +: W]
//     user_valid              : per-channel load strobe (live mode)
//     snap_trig, snap_done    : snapshot trigger and one-cycle completion pulse
//
//   Register map (byte offset)
//     0x00+4*i : holding register of channel i (RO, zero-extended)
//     0x40     : CTRL   IBM bit31 = mode (1 = snapshot), IBM bit30 = arm
//     0x44     : STATUS IBM bit31 = captured (W1C), IBM bits 16..23 = count

// One channel's holding register.
module opb_rb_chan #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge clk or posedge rst)
      if (rst)       q <= '0;
      else if (load) q <= d;
endmodule

module opb_register_bank_simulink2ppc #(
   parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
   parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
   parameter int          C_OPB_AWIDTH = 32,
   parameter int          C_OPB_DWIDTH = 32,
   parameter int          C_NUM_CH     = 4,
   parameter int          C_USER_WIDTH = 32,
   parameter string       C_FAMILY     = "virtex5"
) (
   input  logic                             OPB_Clk,
   input  logic                             OPB_Rst,
   input  logic [0:31]                      OPB_ABus,
   input  logic [0:3]                       OPB_BE,
   input  logic [0:31]                      OPB_DBus,
   input  logic                             OPB_RNW,
   input  logic                             OPB_select,
   input  logic                             OPB_seqAddr,
   output logic [0:31]                      Sl_DBus,
   output logic                             Sl_xferAck,
   output logic                             Sl_errAck,
   output logic                             Sl_retry,
   output logic                             Sl_toutSup,
   input  logic [C_NUM_CH*C_USER_WIDTH-1:0] user_data_in,
   input  logic [C_NUM_CH-1:0]              user_valid,
   input  logic                             snap_trig,
   output logic                             snap_done
);

   typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT} state_t;

   // Request captured when the transfer is accepted; only the fields the
   // write side actually needs are kept.
   typedef struct packed {
      logic       rnw;
      logic [7:0] off;
      logic [1:0] wdata;   // value bits 1:0 = IBM bits 30..31
      logic       be_lo;   // OPB_BE[3], lane holding IBM bits 24..31
   } req_t;

   // Window decode works for any aligned power-of-two window.
   localparam logic [31:0] WIN_MASK = ~(C_HIGHADDR - C_BASEADDR);
   localparam logic [4:0]  NCH      = 5'(C_NUM_CH);
   localparam string       unused_family = C_FAMILY;
   localparam int          unused_widths = C_OPB_AWIDTH + C_OPB_DWIDTH;

   // Declaring these [31:0] flips IBM order into LSB-at-0 order.
   logic [31:0] addr, wdat, rd_mux, rd_q;
   logic [3:0]  be;
   assign addr = OPB_ABus;
   assign wdat = OPB_DBus;
   assign be   = OPB_BE;

   logic unused_bits;
   assign unused_bits = &{1'b0, OPB_seqAddr, wdat[31:2], be[3:1]};

   state_t state, state_nx;
   req_t   req_q;
   logic   hit, start, wr_en, wr_ctrl, wr_stat, cap;
   logic   mode, armed, captured;
   logic [7:0] count;

   logic [C_NUM_CH-1:0]                   load;
   logic [C_NUM_CH-1:0][C_USER_WIDTH-1:0] hold;

   assign hit   = ((addr & WIN_MASK) == (C_BASEADDR & WIN_MASK));
   assign start = (state == S_IDLE) && OPB_select && hit;

   // ---------------------------------------------------------------- bus FSM
   always_ff @(posedge OPB_Clk or posedge OPB_Rst)
      if (OPB_Rst) state <= S_IDLE;
      else         state <= state_nx;

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (start) state_nx = S_ACK;
         S_ACK:   state_nx = S_WAIT;
         S_WAIT:  if (!OPB_select) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Read data is sampled in the accept cycle, so a fabric update landing on
   // that same edge shows up only on the next read.
   always_ff @(posedge OPB_Clk or posedge OPB_Rst)
      if (OPB_Rst) begin
         req_q <= '0;
         rd_q  <= '0;
      end else if (start) begin
         req_q <= '{rnw: OPB_RNW, off: addr[7:0], wdata: wdat[1:0], be_lo: be[0]};
         rd_q  <= OPB_RNW ? rd_mux : '0;
      end

   assign Sl_xferAck = (state == S_ACK);
   assign Sl_DBus    = Sl_xferAck ? rd_q : '0;
   assign Sl_errAck  = 1'b0;
   assign Sl_retry   = 1'b0;
   assign Sl_toutSup = 1'b0;

   // Writes commit on the edge closing the ack cycle.
   assign wr_en   = (state == S_ACK) && !req_q.rnw;
   assign wr_ctrl = wr_en && req_q.be_lo && (req_q.off == 8'h40);
   assign wr_stat = wr_en && req_q.be_lo && (req_q.off == 8'h44);

   // ------------------------------------------------------------ read mux
   logic [3:0] ch_idx;
   logic       ch_hit;
   assign ch_idx = addr[5:2];
   assign ch_hit = (addr[7:6] == 2'b00) && (addr[1:0] == 2'b00) && ({1'b0, ch_idx} < NCH);

   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < C_NUM_CH; i++)
         if (ch_hit && (ch_idx == 4'(i))) rd_mux[C_USER_WIDTH-1:0] = hold[i];
      case (addr[7:0])
         8'h40: rd_mux[1:0] = {armed, mode};
         8'h44: begin
            rd_mux[15:8] = count;     // IBM bits 16..23
            rd_mux[0]    = captured;
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------- control / status
   // Capture uses the registered armed bit, so an arm write committing on the
   // trigger edge cannot capture until the following cycle.
   assign cap = mode && armed && snap_trig;

   always_ff @(posedge OPB_Clk or posedge OPB_Rst)
      if (OPB_Rst) begin
         mode      <= 1'b0;
         armed     <= 1'b0;
         captured  <= 1'b0;
         count     <= '0;
         snap_done <= 1'b0;
      end else begin
         snap_done <= cap;
         if (cap) begin
            armed <= 1'b0;
            count <= count + 8'd1;
         end
         // Set beats a coincident write-1-to-clear.
         if (cap)                            captured <= 1'b1;
         else if (wr_stat && req_q.wdata[0]) captured <= 1'b0;
         // A mode change drops any earlier arm; an arm in the same write
         // still takes effect so mode+arm can be set in one access.
         if (wr_ctrl) begin
            mode <= req_q.wdata[0];
            if (req_q.wdata[1])                armed <= 1'b1;
            else if (req_q.wdata[0] != mode)   armed <= 1'b0;
         end
      end

   // ------------------------------------------------------ holding registers
   for (genvar i = 0; i < C_NUM_CH; i++) begin : g_ch
      assign load[i] = mode ? cap : user_valid[i];
      opb_rb_chan #(.W(C_USER_WIDTH)) u_chan (
         .clk  (OPB_Clk),
         .rst  (OPB_Rst),
         .load (load[i]),
         .d    (user_data_in[i*C_USER_WIDTH +: C_USER_WIDTH]),
         .q    (hold[i])
      );
   end

endmodule

// File: tb/tb_opb_register_bank_simulink2ppc.sv
`timescale 1ns/1ps
module tb_opb_register_bank_simulink2ppc;
   localparam logic [31:0] BASE = 32'h0000_1000;
   localparam int NCH = 4;
   localparam int W   = 12;

   logic          OPB_Clk = 1'b0;
   logic          OPB_Rst = 1'b1;
   logic [0:31]   OPB_ABus = '0, OPB_DBus = '0;
   logic [0:3]    OPB_BE = '0;
   logic          OPB_RNW = 1'b0, OPB_select = 1'b0, OPB_seqAddr = 1'b0;
   logic [0:31]   Sl_DBus;
   logic          Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup;
   logic [NCH*W-1:0] user_data_in = '0;
   logic [NCH-1:0]   user_valid = '0;
   logic          snap_trig = 1'b0;
   logic          snap_done;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   logic [W-1:0] m_hold [NCH];
   logic         m_mode, m_armed, m_cap;
   logic [7:0]   m_cnt;

   always #5 OPB_Clk = ~OPB_Clk;

   opb_register_bank_simulink2ppc #(
      .C_BASEADDR(BASE), .C_HIGHADDR(BASE + 32'hFF),
      .C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32),
      .C_NUM_CH(NCH), .C_USER_WIDTH(W), .C_FAMILY("virtex5")
   ) dut (
      .OPB_Clk(OPB_Clk), .OPB_Rst(OPB_Rst), .OPB_ABus(OPB_ABus), .OPB_BE(OPB_BE),
      .OPB_DBus(OPB_DBus), .OPB_RNW(OPB_RNW), .OPB_select(OPB_select),
      .OPB_seqAddr(OPB_seqAddr), .Sl_DBus(Sl_DBus), .Sl_xferAck(Sl_xferAck),
      .Sl_errAck(Sl_errAck), .Sl_retry(Sl_retry), .Sl_toutSup(Sl_toutSup),
      .user_data_in(user_data_in), .user_valid(user_valid),
      .snap_trig(snap_trig), .snap_done(snap_done)
   );

   // ------------------------------------------------------------ model
   task automatic m_reset();
      for (int i = 0; i < NCH; i++) m_hold[i] = '0;
      m_mode = 0; m_armed = 0; m_cap = 0; m_cnt = '0;
   endtask

   // be[0] is the lane of OPB_BE[3]
   task automatic m_ctrl(input logic [31:0] wd, input logic [3:0] be);
      if (be[0]) begin
         if (wd[1])               m_armed = 1;
         else if (wd[0] != m_mode) m_armed = 0;
         m_mode = wd[0];
      end
   endtask

   task automatic m_stat(input logic [31:0] wd, input logic [3:0] be);
      if (be[0] && wd[0]) m_cap = 0;
   endtask

   task automatic m_trig();
      if (m_mode && m_armed) begin
         for (int i = 0; i < NCH; i++) m_hold[i] = user_data_in[i*W +: W];
         m_armed = 0;
         m_cap   = 1;
         m_cnt   = m_cnt + 8'd1;
      end
   endtask

   function automatic logic [31:0] exp_rd(input logic [7:0] off);
      logic [31:0] r;
      r = '0;
      if (off < 8'h40 && off % 4 == 0 && off / 4 < NCH) r = 32'(m_hold[off / 4]);
      else if (off == 8'h40) r = {30'b0, m_armed, m_mode};
      else if (off == 8'h44) r = {16'b0, m_cnt, 7'b0, m_cap};
      return r;
   endfunction

   task automatic set_ch(input int i, input logic [W-1:0] v);
      user_data_in[i*W +: W] = v;
   endtask

   // ------------------------------------------------------------ bus driver
   // tm: 0 none, 1 snap_trig during the ack cycle, 2 ack cycle and the next
   // one (caller drops it).
   task automatic bus(input logic rnw, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, input int tm,
                      output logic [31:0] rd, output int lat, output logic ack_after);
      logic [31:0] d;
      @(posedge OPB_Clk); #1;
      OPB_select = 1; OPB_RNW = rnw; OPB_ABus = a; OPB_DBus = wd; OPB_BE = be;
      lat = 0; rd = '0;
      for (int n = 1; n <= 6 && lat == 0; n++) begin
         @(negedge OPB_Clk);
         if (Sl_xferAck === 1'b1) begin
            lat = n; d = Sl_DBus; rd = d;
            if (tm != 0) snap_trig = 1;
         end
      end
      @(posedge OPB_Clk); #1;
      OPB_select = 0; OPB_RNW = 0; OPB_DBus = '0; OPB_BE = '0;
      if (tm == 1) snap_trig = 0;
      @(negedge OPB_Clk);
      ack_after = Sl_xferAck;
   endtask

   task automatic capture_once();
      logic [31:0] rd; int lat; logic aa;
      bus(0, BASE + 32'h40, 32'h3, 4'hF, 0, rd, lat, aa);
      m_ctrl(32'h3, 4'hF);
      for (int i = 0; i < NCH; i++) set_ch(i, W'($urandom));
      @(posedge OPB_Clk); #1; snap_trig = 1; m_trig();
      @(posedge OPB_Clk); #1; snap_trig = 0;
   endtask

   // ------------------------------------------------------------ tests
   task automatic test_reset();
      logic [31:0] rd; int lat; logic aa;
      logic [7:0] offs [3] = '{8'h00, 8'h40, 8'h44};
      m_reset();
      repeat (3) @(posedge OPB_Clk);
      @(negedge OPB_Clk);
      n_vec++;
      if ({Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup, snap_done} !== 5'b0 || Sl_DBus !== 32'h0) begin
         n_err++; $display("FAIL reset_outputs got ack%b dbus=%h done=%b want all 0", Sl_xferAck, Sl_DBus, snap_done);
      end
      @(posedge OPB_Clk); #1; OPB_Rst = 0;
      foreach (offs[k]) begin
         bus(1, BASE + 32'(offs[k]), '0, 4'hF, 0, rd, lat, aa);
         n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL reset_read off=%h got %h want 0", offs[k], rd); end
         n_vec++; if (lat != 2) begin n_err++; $display("FAIL reset_latency off=%h got %0d want 2", offs[k], lat); end
         n_vec++; if (aa !== 1'b0) begin n_err++; $display("FAIL ack_width off=%h ack still %b want 0", offs[k], aa); end
      end
   endtask

   task automatic test_live_ch2();
      logic [31:0] rd; int lat; logic aa;
      @(posedge OPB_Clk); #1; set_ch(2, 12'hABC); user_valid = 4'b0100;
      m_hold[2] = 12'hABC;
      @(posedge OPB_Clk); #1; user_valid = '0;
      bus(1, BASE + 32'h08, '0, 4'hF, 0, rd, lat, aa);
      n_vec++; if (rd !== 32'h0000_0ABC) begin n_err++; $display("FAIL live_ch2 got %h want 00000abc", rd); end
      set_ch(2, 12'h123);
      repeat (3) @(posedge OPB_Clk);
      bus(1, BASE + 32'h08, '0, 4'hF, 0, rd, lat, aa);
      n_vec++; if (rd !== exp_rd(8'h08)) begin n_err++; $display("FAIL live_novalid got %h want %h", rd, exp_rd(8'h08)); end
   endtask

   task automatic test_live_random();
      logic [31:0] rd, v; int lat; logic aa;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 30; c++) begin
            @(posedge OPB_Clk); #1;
            v = $urandom;
            user_valid = v[NCH-1:0];
            for (int i = 0; i < NCH; i++) set_ch(i, W'($urandom));
            for (int i = 0; i < NCH; i++) if (v[i]) m_hold[i] = user_data_in[i*W +: W];
         end
         @(posedge OPB_Clk); #1; user_valid = '0;
         for (int i = 0; i < NCH; i++) begin
            bus(1, BASE + 32'(4*i), '0, 4'hF, 0, rd, lat, aa);
            n_vec++; if (rd !== exp_rd(8'(4*i))) begin n_err++; $display("FAIL live_rand ch%0d got %h want %h", i, rd, exp_rd(8'(4*i))); end
         end
      end
   endtask

   task automatic test_decode();
      logic [31:0] rd; int lat; logic aa;
      bus(1, BASE + 32'h100, '0, 4'hF, 0, rd, lat, aa);
      n_vec++; if (lat != 0) begin n_err++; $display("FAIL decode_above acked at %0d want none", lat); end
      bus(1, BASE - 32'h4, '0, 4'hF, 0, rd, lat, aa);
      n_vec++; if (lat != 0) begin n_err++; $display("FAIL decode_below acked at %0d want none", lat); end
      bus(1, BASE + 32'h80, '0, 4'hF, 0, rd, lat, aa);
      n_vec++; if (rd !== 32'h0 || lat != 2) begin n_err++; $display("FAIL decode_unmapped got %h lat %0d want 0 lat 2", rd, lat); end
      bus(1, BASE + 32'h09, '0, 4'hF, 0, rd, lat, aa);
      n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL decode_unaligned got %h want 0", rd); end
      bus(1, BASE + 32'h10, '0, 4'hF, 0, rd, lat, aa);
      n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL decode_nochan got %h want 0", rd); end
   endtask

   task automatic test_snapshot();
      logic [31:0] rd; int lat; logic aa;
      logic [7:0] offs [2] = '{8'h44, 8'h40};
      bus(0, BASE + 32'h40, 32'h3, 4'hF, 0, rd, lat, aa);
      m_ctrl(32'h3, 4'hF);
      for (int i = 0; i < NCH; i++) set_ch(i, W'(12'h100 * (i + 1) + $urandom_range(0, 255)));
      @(posedge OPB_Clk); #1; snap_trig = 1; m_trig();
      @(negedge OPB_Clk);
      n_vec++; if (snap_done !== 1'b0) begin n_err++; $display("FAIL snap_done_early got %b want 0", snap_done); end
      @(posedge OPB_Clk); #1; snap_trig = 0;
      for (int i = 0; i < NCH; i++) set_ch(i, W'($urandom));
      user_valid = '1;                              // ignored in snapshot mode
      @(negedge OPB_Clk);
      n_vec++; if (snap_done !== 1'b1) begin n_err++; $display("FAIL snap_done got %b want 1", snap_done); end
      @(posedge OPB_Clk); #1; user_valid = '0;
      @(negedge OPB_Clk);
      n_vec++; if (snap_done !== 1'b0) begin n_err++; $display("FAIL snap_done_width got %b want 0", snap_done); end
      // trigger while disarmed does nothing
      @(posedge OPB_Clk); #1; snap_trig = 1; m_trig();
      @(posedge OPB_Clk); #1; snap_trig = 0;
      for (int i = 0; i < NCH; i++) begin
         bus(1, BASE + 32'(4*i), '0, 4'hF, 0, rd, lat, aa);
         n_vec++; if (rd !== exp_rd(8'(4*i))) begin n_err++; $display("FAIL snap_ch%0d got %h want %h", i, rd, exp_rd(8'(4*i))); end
      end
      foreach (offs[k]) begin
         bus(1, BASE + 32'(offs[k]), '0, 4'hF, 0, rd, lat, aa);
         n_vec++; if (rd !== exp_rd(offs[k])) begin n_err++; $display("FAIL snap_reg off=%h got %h want %h", offs[k], rd, exp_rd(offs[k])); end
      end
   endtask

   task automatic test_arm_trig();
      logic [31:0] rd; int lat; logic aa;
      for (int i = 0; i < NCH; i++) set_ch(i, W'($urandom));
      // arm commits on the trigger edge: no capture
      bus(0, BASE + 32'h40, 32'h3, 4'hF, 1, rd, lat, aa);
      m_trig(); m_ctrl(32'h3, 4'hF);
      bus(1, BASE + 32'h44, '0, 4'hF, 0, rd, lat, aa);
      n_vec++; if (rd !== exp_rd(8'h44)) begin n_err++; $display("FAIL armtrig_status got %h want %h", rd, exp_rd(8'h44)); end
      bus(1, BASE + 32'h40, '0, 4'hF, 0, rd, lat, aa);
      n_vec++; if (rd !== exp_rd(8'h40)) begin n_err++; $display("FAIL armtrig_ctrl got %h want %h", rd, exp_rd(8'h40)); end
      bus(1, BASE + 32'h00, '0, 4'hF, 0, rd, lat, aa);
      n_vec++; if (rd !== exp_rd(8'h00)) begin n_err++; $display("FAIL armtrig_ch0 got %h want %h", rd, exp_rd(8'h00)); end
      // leave snapshot (clears arm), then mode+arm with trigger held two cycles
      bus(0, BASE + 32'h40, 32'h0, 4'hF, 0, rd, lat, aa);
      m_ctrl(32'h0, 4'hF);
      bus(0, BASE + 32'h40, 32'h3, 4'hF, 2, rd, lat, aa);
      m_trig(); m_ctrl(32'h3, 4'hF); m_trig();
      @(posedge OPB_Clk); #1; snap_trig = 0;
      @(negedge OPB_Clk);
      n_vec++; if (snap_done !== 1'b1) begin n_err++; $display("FAIL armtrig_done got %b want 1", snap_done); end
      bus(1, BASE + 32'h44, '0, 4'hF, 0, rd, lat, aa);
      n_vec++; if (rd !== exp_rd(8'h44)) begin n_err++; $display("FAIL armtrig2_status got %h want %h", rd, exp_rd(8'h44)); end
      bus(1, BASE + 32'h0C, '0, 4'hF, 0, rd, lat, aa);
      n_vec++; if (rd !== exp_rd(8'h0C)) begin n_err++; $display("FAIL armtrig2_ch3 got %h want %h", rd, exp_rd(8'h0C)); end
   endtask

   task automatic test_wrap_w1c();
      logic [31:0] rd; int lat; logic aa;
      while (m_cnt != 8'd255) capture_once();
      bus(1, BASE + 32'h44, '0, 4'hF, 0, rd, lat, aa);
      n_vec++; if (rd !== exp_rd(8'h44)) begin n_err++; $display("FAIL count_255 got %h want %h", rd, exp_rd(8'h44)); end
      capture_once();
      bus(1, BASE + 32'h44, '0, 4'hF, 0, rd, lat, aa);
      n_vec++; if (rd !== 32'h0000_0001) begin n_err++; $display("FAIL count_wrap got %h want 00000001", rd); end
      bus(1, BASE + 32'h04, '0, 4'hF, 0, rd, lat, aa);
      n_vec++; if (rd !== exp_rd(8'h04)) begin n_err++; $display("FAIL wrap_ch1 got %h want %h", rd, exp_rd(8'h04)); end
      // W1C coincident with a capture: set wins
      bus(0, BASE + 32'h40, 32'h3, 4'hF, 0, rd, lat, aa);
      m_ctrl(32'h3, 4'hF);
      bus(0, BASE + 32'h44, 32'h1, 4'hF, 1, rd, lat, aa);
      m_stat(32'h1, 4'hF); m_trig();
      bus(1, BASE + 32'h44, '0, 4'hF, 0, rd, lat, aa);
      n_vec++; if (rd !== exp_rd(8'h44)) begin n_err++; $display("FAIL w1c_vs_cap got %h want %h", rd, exp_rd(8'h44)); end
      bus(0, BASE + 32'h44, 32'h1, 4'hF, 0, rd, lat, aa);
      m_stat(32'h1, 4'hF);
      bus(1, BASE + 32'h44, '0, 4'hF, 0, rd, lat, aa);
      n_vec++; if (rd !== exp_rd(8'h44)) begin n_err++; $display("FAIL w1c got %h want %h", rd, exp_rd(8'h44)); end
   endtask

   task automatic test_be_ignore();
      logic [31:0] rd; int lat; logic aa;
      capture_once();
      bus(0, BASE + 32'h40, 32'h0, 4'b1110, 0, rd, lat, aa);
      m_ctrl(32'h0, 4'b1110);
      bus(1, BASE + 32'h40, '0, 4'hF, 0, rd, lat, aa);
      n_vec++; if (rd !== exp_rd(8'h40) || lat != 2) begin n_err++; $display("FAIL be_ctrl got %h want %h", rd, exp_rd(8'h40)); end
      bus(0, BASE + 32'h44, 32'h1, 4'b1110, 0, rd, lat, aa);
      m_stat(32'h1, 4'b1110);
      bus(1, BASE + 32'h44, '0, 4'hF, 0, rd, lat, aa);
      n_vec++; if (rd !== exp_rd(8'h44)) begin n_err++; $display("FAIL be_status got %h want %h", rd, exp_rd(8'h44)); end
      bus(0, BASE + 32'h00, 32'hFFFF_FFFF, 4'hF, 0, rd, lat, aa);
      n_vec++; if (lat != 2) begin n_err++; $display("FAIL hold_write_ack lat %0d want 2", lat); end
      bus(1, BASE + 32'h00, '0, 4'hF, 0, rd, lat, aa);
      n_vec++; if (rd !== exp_rd(8'h00)) begin n_err++; $display("FAIL hold_write got %h want %h", rd, exp_rd(8'h00)); end
   endtask

   task automatic test_hold_select();
      logic [31:0] d, seen; int acks;
      acks = 0; seen = '0;
      @(posedge OPB_Clk); #1;
      OPB_select = 1; OPB_RNW = 1; OPB_ABus = BASE + 32'h44; OPB_BE = 4'hF;
      for (int n = 0; n < 8; n++) begin
         @(negedge OPB_Clk);
         if (Sl_xferAck === 1'b1) begin acks++; d = Sl_DBus; seen = d; end
      end
      @(posedge OPB_Clk); #1; OPB_select = 0; OPB_RNW = 0;
      @(negedge OPB_Clk);
      n_vec++; if (acks != 1) begin n_err++; $display("FAIL held_select acks %0d want 1", acks); end
      n_vec++; if (seen !== exp_rd(8'h44)) begin n_err++; $display("FAIL held_select_data got %h want %h", seen, exp_rd(8'h44)); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd, d; int lat; logic aa;
      logic [7:0] offs [6] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h40, 8'h44};
      @(posedge OPB_Clk); #1;
      OPB_select = 1; OPB_RNW = 1; OPB_ABus = BASE + 32'h00; OPB_BE = 4'hF;
      @(posedge OPB_Clk); #1; OPB_Rst = 1;           // FSM is in ACK now
      @(negedge OPB_Clk);
      n_vec++; if (Sl_xferAck !== 1'b0) begin n_err++; $display("FAIL rst_mid_ack got %b want 0", Sl_xferAck); end
      @(posedge OPB_Clk); #1; OPB_Rst = 0; m_reset();
      @(negedge OPB_Clk);
      n_vec++; if (Sl_xferAck !== 1'b0) begin n_err++; $display("FAIL rst_release_ack got %b want 0", Sl_xferAck); end
      @(negedge OPB_Clk);
      d = Sl_DBus;
      n_vec++; if (Sl_xferAck !== 1'b1 || d !== 32'h0) begin n_err++; $display("FAIL rst_new_xfer ack %b data %h want 1 0", Sl_xferAck, d); end
      @(posedge OPB_Clk); #1; OPB_select = 0; OPB_RNW = 0;
      @(negedge OPB_Clk);
      foreach (offs[k]) begin
         bus(1, BASE + 32'(offs[k]), '0, 4'hF, 0, rd, lat, aa);
         n_vec++; if (rd !== exp_rd(offs[k])) begin n_err++; $display("FAIL rst_mid_reg off=%h got %h want %h", offs[k], rd, exp_rd(offs[k])); end
      end
   endtask

   initial begin
      test_reset();
      test_live_ch2();
      test_live_random();
      test_decode();
      test_snapshot();
      test_arm_trig();
      test_wrap_w1c();
      test_be_ignore();
      test_hold_select();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
